// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, funct
// codes, FSM states, ALU operations, datapath mux selects and the helpers
// that classify an instruction and derive the per-state control word.
package mc_pkg;

    // Opcode field values
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Funct field values for R-type instructions
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    // Next-PC source
    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_RS     = 2'd3;

    // Register file write address
    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    // Register file write data
    localparam logic [1:0] WD_ALUOUT = 2'd0;
    localparam logic [1:0] WD_MDR    = 2'd1;
    localparam logic [1:0] WD_PC     = 2'd2;
    localparam logic [1:0] WD_LUI    = 2'd3;

    // ALU B operand
    localparam logic [1:0] ALU_B_RT      = 2'd0;
    localparam logic [1:0] ALU_B_FOUR    = 2'd1;
    localparam logic [1:0] ALU_B_IMM     = 2'd2;
    localparam logic [1:0] ALU_B_IMM_SH2 = 2'd3;

    typedef enum logic [3:0] {
        CLS_R_ALU   = 4'd0,
        CLS_ADDIU   = 4'd1,
        CLS_ORI     = 4'd2,
        CLS_LW      = 4'd3,
        CLS_SW      = 4'd4,
        CLS_BEQ     = 4'd5,
        CLS_J       = 4'd6,
        CLS_JAL     = 4'd7,
        CLS_JR      = 4'd8,
        CLS_LUI     = 4'd9,
        CLS_ILLEGAL = 4'd15
    } iclass_t;

    // Registered (state-decoded) part of the control word. pc_we here only
    // covers the unconditional jumps; fetch and branch writes are added
    // combinationally by the top.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       alu_a_sel;
        logic [1:0] alu_b_sel;
        logic [3:0] alu_ctrl;
        logic       ext_op;
    } ctrl_t;

    // Sort the current instruction into an execution class.
    function automatic iclass_t mc_classify(input logic [5:0] op,
                                            input logic       r_alu_ok,
                                            input logic       r_is_jr);
        iclass_t cls;
        cls = CLS_ILLEGAL;
        case (op)
            OP_RTYPE: begin
                if (r_alu_ok) begin
                    cls = CLS_R_ALU;
                end else if (r_is_jr) begin
                    cls = CLS_JR;
                end else begin
                    cls = CLS_ILLEGAL;
                end
            end
            OP_J:     cls = CLS_J;
            OP_JAL:   cls = CLS_JAL;
            OP_BEQ:   cls = CLS_BEQ;
            OP_ADDIU: cls = CLS_ADDIU;
            OP_ORI:   cls = CLS_ORI;
            OP_LUI:   cls = CLS_LUI;
            OP_LW:    cls = CLS_LW;
            OP_SW:    cls = CLS_SW;
            default:  cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    // Control word that a state presents for its whole duration.
    function automatic ctrl_t mc_state_ctrl(input state_t     st,
                                            input iclass_t    cls,
                                            input logic [3:0] r_alu_ctrl);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH: begin
                c.mem_req   = 1'b1;
                c.iord      = 1'b0;
                c.alu_a_sel = 1'b0;
                c.alu_b_sel = ALU_B_FOUR;
                c.alu_ctrl  = ALU_ADD;
                c.pc_src    = PC_SRC_ALU;
            end
            ST_DECODE: begin
                c.alu_a_sel = 1'b0;
                c.alu_b_sel = ALU_B_IMM_SH2;
                c.ext_op    = 1'b1;
                c.alu_ctrl  = ALU_ADD;
            end
            ST_EXEC: begin
                case (cls)
                    CLS_R_ALU: begin
                        c.alu_a_sel = 1'b1;
                        c.alu_b_sel = ALU_B_RT;
                        c.alu_ctrl  = r_alu_ctrl;
                    end
                    CLS_ADDIU, CLS_LW, CLS_SW: begin
                        c.alu_a_sel = 1'b1;
                        c.alu_b_sel = ALU_B_IMM;
                        c.ext_op    = 1'b1;
                        c.alu_ctrl  = ALU_ADD;
                    end
                    CLS_ORI: begin
                        c.alu_a_sel = 1'b1;
                        c.alu_b_sel = ALU_B_IMM;
                        c.ext_op    = 1'b0;
                        c.alu_ctrl  = ALU_OR;
                    end
                    CLS_BEQ: begin
                        c.alu_a_sel = 1'b1;
                        c.alu_b_sel = ALU_B_RT;
                        c.alu_ctrl  = ALU_SUB;
                        c.pc_src    = PC_SRC_ALUOUT;
                    end
                    CLS_J: begin
                        c.pc_we  = 1'b1;
                        c.pc_src = PC_SRC_JUMP;
                    end
                    CLS_JAL: begin
                        c.pc_we   = 1'b1;
                        c.pc_src  = PC_SRC_JUMP;
                        c.reg_we  = 1'b1;
                        c.reg_dst = REG_DST_RA;
                        c.wd_sel  = WD_PC;
                    end
                    CLS_JR: begin
                        c.pc_we  = 1'b1;
                        c.pc_src = PC_SRC_RS;
                    end
                    CLS_LUI: begin
                        c.reg_we  = 1'b1;
                        c.reg_dst = REG_DST_RT;
                        c.wd_sel  = WD_LUI;
                    end
                    default: c = '0;
                endcase
            end
            ST_MEM: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
                c.mem_we  = (cls == CLS_SW);
            end
            ST_WB: begin
                case (cls)
                    CLS_R_ALU: begin
                        c.reg_we  = 1'b1;
                        c.reg_dst = REG_DST_RD;
                        c.wd_sel  = WD_ALUOUT;
                    end
                    CLS_ADDIU, CLS_ORI: begin
                        c.reg_we  = 1'b1;
                        c.reg_dst = REG_DST_RT;
                        c.wd_sel  = WD_ALUOUT;
                    end
                    CLS_LW: begin
                        c.reg_we  = 1'b1;
                        c.reg_dst = REG_DST_RT;
                        c.wd_sel  = WD_MDR;
                    end
                    default: c = '0;
                endcase
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle between the multi-cycle controller and the datapath/memory:
// instruction fields and status in, every enable and select out.
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_a_sel;
    logic [1:0] alu_b_sel;
    logic [3:0] alu_ctrl;
    logic       ext_op;
    logic       illegal;
    logic [2:0] state;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
               wd_sel, alu_a_sel, alu_b_sel, alu_ctrl, ext_op, illegal, state
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
               wd_sel, alu_a_sel, alu_b_sel, alu_ctrl, ext_op, illegal, state
    );
endinterface

// File: rtl/mc_alu_dec.sv
// Combinational R-type funct decoder: ALU operation, whether the funct is a
// supported register-register ALU op, and whether it is jr.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       r_alu_ok,
    output logic       r_is_jr
);

    // Map funct to an ALU operation and legality flags
    always_comb begin
        alu_ctrl = ALU_ADD;
        r_alu_ok = 1'b0;
        r_is_jr  = 1'b0;
        case (funct)
            FN_ADDU: begin alu_ctrl = ALU_ADD; r_alu_ok = 1'b1; end
            FN_SUBU: begin alu_ctrl = ALU_SUB; r_alu_ok = 1'b1; end
            FN_AND:  begin alu_ctrl = ALU_AND; r_alu_ok = 1'b1; end
            FN_OR:   begin alu_ctrl = ALU_OR;  r_alu_ok = 1'b1; end
            FN_SLT:  begin alu_ctrl = ALU_SLT; r_alu_ok = 1'b1; end
            FN_JR:   begin r_is_jr = 1'b1; end
            default: begin alu_ctrl = ALU_ADD; r_alu_ok = 1'b0; end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM. Sequences fetch/decode/execute/memory/
// write-back and shares a single memory port between instruction and data.
// The per-state control word is computed for the next state and registered,
// so it is glitch-free and all-zero under reset. Only the fetch ir_we/pc_we
// pulse, the beq pc_we and the in-DECODE illegal indication depend on inputs
// in the current cycle.
module multicycle_ctrl
    import mc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
);

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    ctrl_t      ctrl_q, ctrl_d;

    logic [3:0] r_alu_ctrl_s;
    logic       r_alu_ok_s;
    logic       r_is_jr_s;
    iclass_t    cls_s;
    logic       ir_we_s;
    logic       pc_we_s;
    logic       illegal_s;

    mc_alu_dec u_alu_dec (
        .funct    (bus.funct),
        .alu_ctrl (r_alu_ctrl_s),
        .r_alu_ok (r_alu_ok_s),
        .r_is_jr  (r_is_jr_s)
    );

    assign cls_s = mc_classify(bus.op, r_alu_ok_s, r_is_jr_s);

    // Next-state, sticky illegal flag and next control word
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                // PC already points past the bad instruction, so just refetch
                if (cls_s == CLS_ILLEGAL) begin
                    illegal_d = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls_s)
                    CLS_R_ALU, CLS_ADDIU, CLS_ORI: state_d = ST_WB;
                    CLS_LW, CLS_SW:                state_d = ST_MEM;
                    default:                       state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (!bus.mem_ready) begin
                    state_d = ST_MEM;
                end else if (cls_s == CLS_SW) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ctrl_d = mc_state_ctrl(state_d, cls_s, r_alu_ctrl_s);
    end

    // FSM state, sticky illegal flag and registered control word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            illegal_q <= 1'b0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            ctrl_q    <= ctrl_d;
        end
    end

    // Input-dependent strobes layered on top of the registered control word
    always_comb begin
        ir_we_s   = 1'b0;
        pc_we_s   = ctrl_q.pc_we;
        illegal_s = illegal_q;
        case (state_q)
            ST_FETCH: begin
                ir_we_s = bus.mem_ready;
                pc_we_s = bus.mem_ready;
            end
            ST_DECODE: begin
                illegal_s = illegal_q | (cls_s == CLS_ILLEGAL);
            end
            ST_EXEC: begin
                if (cls_s == CLS_BEQ) begin
                    pc_we_s = bus.zero;
                end else begin
                    pc_we_s = ctrl_q.pc_we;
                end
            end
            default: begin
                ir_we_s = 1'b0;
            end
        endcase
    end

    assign bus.mem_req   = ctrl_q.mem_req;
    assign bus.mem_we    = ctrl_q.mem_we;
    assign bus.iord      = ctrl_q.iord;
    assign bus.ir_we     = ir_we_s;
    assign bus.pc_we     = pc_we_s;
    assign bus.pc_src    = ctrl_q.pc_src;
    assign bus.reg_we    = ctrl_q.reg_we;
    assign bus.reg_dst   = ctrl_q.reg_dst;
    assign bus.wd_sel    = ctrl_q.wd_sel;
    assign bus.alu_a_sel = ctrl_q.alu_a_sel;
    assign bus.alu_b_sel = ctrl_q.alu_b_sel;
    assign bus.alu_ctrl  = ctrl_q.alu_ctrl;
    assign bus.ext_op    = ctrl_q.ext_op;
    assign bus.illegal   = illegal_s;
    assign bus.state     = state_q;

endmodule
